// File: rtl/clk_buffer.sv
// clk_buffer: root clock buffer with glitch-free gate, reset-release synchronizer and divided clock
// Ports:
//   clk_in      - source clock, any duty cycle
//   rst_n       - asynchronous active-low reset
//   clk_en      - gate enable, may be asynchronous to clk_in
//   clk_out     - gated copy of clk_in
//   clk_div_out - clk_in divided by DIV, gated by the same enable
//   active      - high while the gate is open
module clk_buffer #(
    parameter int DIV         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clk_en,
    output logic clk_out,
    output logic clk_div_out,
    output logic active
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync_n;
    logic                   en_q;

    if (!(DIV == 1 || (DIV >= 2 && DIV <= 256 && DIV % 2 == 0))) begin : g_bad_div
        $error("clk_buffer: DIV must be 1 or an even value from 2 to 256");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("clk_buffer: SYNC_STAGES must be 2 to 4");
    end

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], 1'b1};

    assign rst_sync_n = sync[SYNC_STAGES-1];

    // Enable only moves while clk_in is low, so the AND gate below never chops a high phase.
    always_ff @(negedge clk_in or negedge rst_n)
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= clk_en & rst_sync_n;

    assign clk_out = clk_in & en_q;
    assign active  = en_q;

    if (DIV == 1) begin : g_nodiv
        assign clk_div_out = clk_out;
    end else begin : g_div
        localparam logic [7:0] HALF = 8'(DIV / 2 - 1);
        logic [7:0] cnt;
        logic       div_q;
        // Counter and output hold while gated so the divided clock resumes without a short pulse.
        always_ff @(posedge clk_in or negedge rst_n)
            if (!rst_n) begin
                cnt   <= '0;
                div_q <= 1'b0;
            end else if (en_q) begin
                cnt   <= (cnt == HALF) ? 8'd0 : cnt + 8'd1;
                div_q <= (cnt == HALF) ? ~div_q : div_q;
            end
        assign clk_div_out = div_q;
    end
endmodule

// File: tb/tb_clk_buffer.sv
// tb_clk_buffer: self-checking bench for clk_buffer against an edge-counting reference model
module tb_clk_buffer;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;
    logic out_a, div_a, act_a;
    logic out_b, div_b, act_b;
    logic out_c, div_c, act_c;
    int   checks = 0;
    int   errors = 0;
    int   rel    = 0;
    int   n      = 0;
    logic m_en2  = 1'b0;
    logic m_en3  = 1'b0;
    time  t_rise = 0;

    always #5 clk_in = ~clk_in;

    clk_buffer #(.DIV(4), .SYNC_STAGES(2)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .clk_en(clk_en),
        .clk_out(out_a), .clk_div_out(div_a), .active(act_a));
    clk_buffer #(.DIV(1), .SYNC_STAGES(3)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .clk_en(clk_en),
        .clk_out(out_b), .clk_div_out(div_b), .active(act_b));
    clk_buffer #(.DIV(2), .SYNC_STAGES(2)) dut_c (
        .clk_in(clk_in), .rst_n(rst_n), .clk_en(clk_en),
        .clk_out(out_c), .clk_div_out(div_c), .active(act_c));

    // Reference model: rel counts rising edges since reset release, n counts rising edges
    // seen with the gate open; the divided clock is floor(n / (DIV/2)) mod 2.
    always @(posedge clk_in)
        if (rst_n) begin
            rel = rel + 1;
            if (m_en2) n = n + 1;
        end

    always @(negedge clk_in)
        if (rst_n) begin
            m_en2 = clk_en && rel >= 2;
            m_en3 = clk_en && rel >= 3;
        end

    always @(negedge rst_n) begin
        rel   = 0;
        n     = 0;
        m_en2 = 1'b0;
        m_en3 = 1'b0;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_clk_out", out_a, clk_in & m_en2);
        chk("a_active", act_a, m_en2);
        chk("a_div4", div_a, ((n / 2) % 2) == 1);
        chk("b_clk_out", out_b, clk_in & m_en3);
        chk("b_active", act_b, m_en3);
        chk("b_div1", div_b, clk_in & m_en3);
        chk("c_clk_out", out_c, clk_in & m_en2);
        chk("c_active", act_c, m_en2);
        chk("c_div2", div_c, (n % 2) == 1);
    endtask

    task automatic half(input int k);
        repeat (k) begin
            @(posedge clk_in or negedge clk_in);
            #1;
            check_all();
        end
    endtask

    always @(posedge out_a) begin
        t_rise = $time;
        chk("a_rise_on_clk", clk_in, 1'b1);
    end

    always @(negedge out_a)
        if (rst_n) chk("a_full_pulse", ($time - t_rise) == 5, 1'b1);

    always @(div_a)
        if (rst_n) chk("a_div_edge_on_rise", clk_in, 1'b1);

    initial begin
        #11;
        check_all();
        #1 rst_n = 1'b1;
        half(50);
        @(posedge clk_in);
        #2 clk_en = 1'b0;
        half(8);
        #2 clk_en = 1'b1;
        half(10);
        @(posedge clk_in);
        #2 clk_en = 1'b0;
        half(6);
        #2 clk_en = 1'b1;
        half(12);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_high_clk_out", out_a, 1'b0);
        chk("rst_mid_high_active", act_a, 1'b0);
        chk("rst_mid_high_div", div_a, 1'b0);
        check_all();
        half(4);
        #2 rst_n = 1'b1;
        half(20);
        for (int i = 0; i < 400; i++) begin
            half($urandom_range(1, 4));
            #($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                #1;
                check_all();
                #1 rst_n = 1'b1;
            end else begin
                clk_en = ($urandom_range(0, 3) != 0);
            end
        end
        half(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
